// File: rtl/move_controller.sv
// Game-state stage: holds the authoritative 8x8 board, the selected piece and the side to move,
// and commits pick/place moves subject to colour and turn ownership checks only.
module move_controller (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              mouse_position,
  input  logic                    pick_piece,
  input  logic                    place_piece,
  output logic [0:7][0:7][3:0]    board,
  output logic                    held,
  output logic [5:0]              sel_square,
  output logic                    turn,
  output logic                    move_done,
  output logic [3:0]              captured,
  output logic                    game_over
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
    S_COMMIT,
    S_OVER
  } state_t;

  localparam logic [2:0] KING = 3'd6;

  function automatic logic [0:7][0:7][3:0] start_board();
    logic [0:7][0:7][3:0] b;
    b    = '0;
    b[0] = {4'hC, 4'hA, 4'hB, 4'hD, 4'hE, 4'hB, 4'hA, 4'hC};
    b[1] = {8{4'h9}};
    b[6] = {8{4'h1}};
    b[7] = {4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4};
    return b;
  endfunction

  state_t               r_state;
  logic [0:7][0:7][3:0] r_board;
  logic                 r_held;
  logic [5:0]           r_sel;
  logic [5:0]           r_dst;
  logic [3:0]           r_dst_val;
  logic                 r_turn;
  logic                 r_move_done;
  logic [3:0]           r_captured;
  logic                 r_game_over;
  logic                 r_pick_q;
  logic                 r_place_q;

  logic                 w_pick_rise;
  logic                 w_place_rise;
  logic                 w_pick_req;
  logic                 w_place_req;
  logic [3:0]           w_pos_val;
  logic [3:0]           w_src_val;
  logic                 w_pos_own;

  // Coincident pick and place edges cancel each other out.
  assign w_pick_rise  = pick_piece  & ~r_pick_q;
  assign w_place_rise = place_piece & ~r_place_q;
  assign w_pick_req   = w_pick_rise  & ~w_place_rise;
  assign w_place_req  = w_place_rise & ~w_pick_rise;

  assign w_pos_val = r_board[mouse_position[5:3]][mouse_position[2:0]];
  assign w_src_val = r_board[r_sel[5:3]][r_sel[2:0]];
  assign w_pos_own = (w_pos_val != 4'h0) && (w_pos_val[3] == r_turn);

  // NOTE: the board is a register array with a reset value, not a RAM, so resetting it is intended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_board     <= start_board();
      r_held      <= 1'b0;
      r_sel       <= '0;
      r_dst       <= '0;
      r_dst_val   <= '0;
      r_turn      <= 1'b0;
      r_move_done <= 1'b0;
      r_captured  <= '0;
      r_game_over <= 1'b0;
      r_pick_q    <= 1'b0;
      r_place_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every read below sees the pre-edge value.
      r_pick_q    <= pick_piece;
      r_place_q   <= place_piece;
      r_move_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_req && w_pos_own) begin
            r_sel   <= mouse_position;
            r_held  <= 1'b1;
            r_state <= S_HELD;
          end
        end
        S_HELD: begin
          if (w_place_req) begin
            if (mouse_position == r_sel) begin
              r_held  <= 1'b0;
              r_state <= S_IDLE;
            end else if (!w_pos_own) begin
              r_dst     <= mouse_position;
              r_dst_val <= w_pos_val;
              r_state   <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          r_board[r_dst[5:3]][r_dst[2:0]] <= w_src_val;
          r_board[r_sel[5:3]][r_sel[2:0]] <= 4'h0;
          r_captured  <= r_dst_val;
          r_move_done <= 1'b1;
          r_held      <= 1'b0;
          r_turn      <= ~r_turn;
          if (r_dst_val[2:0] == KING) begin
            r_game_over <= 1'b1;
            r_state     <= S_OVER;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_OVER: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign board      = r_board;
  assign held       = r_held;
  assign sel_square = r_sel;
  assign turn       = r_turn;
  assign move_done  = r_move_done;
  assign captured   = r_captured;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_move_controller.sv
// Scoreboard bench for move_controller: a request-level board model predicts every commit and
// the steady state after each request; a monitor checks each move_done pulse against the queue.
module tb_move_controller;

  logic                 clk;
  logic                 rst;
  logic [5:0]           mouse_position;
  logic                 pick_piece;
  logic                 place_piece;
  logic [0:7][0:7][3:0] board;
  logic                 held;
  logic [5:0]           sel_square;
  logic                 turn;
  logic                 move_done;
  logic [3:0]           captured;
  logic                 game_over;

  move_controller dut (
    .clk            (clk),
    .rst            (rst),
    .mouse_position (mouse_position),
    .pick_piece     (pick_piece),
    .place_piece    (place_piece),
    .board          (board),
    .held           (held),
    .sel_square     (sel_square),
    .turn           (turn),
    .move_done      (move_done),
    .captured       (captured),
    .game_over      (game_over)
  );

  typedef struct {
    logic [0:7][0:7][3:0] b;
    logic                 t;
    logic [3:0]           cap;
    logic                 over;
    int                   cyc;
  } exp_t;

  typedef enum {K_NONE, K_SELECT, K_CANCEL, K_COMMIT} kind_t;

  exp_t                 exp_q[$];
  logic [0:7][0:7][3:0] m_board;
  logic                 m_held;
  logic [5:0]           m_sel;
  logic                 m_turn;
  logic                 m_over;
  kind_t                m_kind;
  int                   cyc;
  int                   n_pass;
  int                   n_total;
  logic                 md_prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] sq_val(input logic [5:0] s);
    return m_board[s[5:3]][s[2:0]];
  endfunction

  function automatic void model_reset();
    logic [3:0] back [8] = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
    m_board = '0;
    for (int c = 0; c < 8; c++) begin
      m_board[7][c] = back[c];
      m_board[6][c] = 4'd1;
      m_board[1][c] = 4'd1 + 4'd8;
      m_board[0][c] = back[c] + 4'd8;
    end
    m_held = 1'b0;
    m_sel  = '0;
    m_turn = 1'b0;
    m_over = 1'b0;
    exp_q.delete();
  endfunction

  function automatic bit own_piece(input logic [5:0] s);
    return sq_val(s) != 4'h0 && sq_val(s)[3] == m_turn;
  endfunction

  function automatic void model_pick(input logic [5:0] s);
    m_kind = K_NONE;
    if (m_over || m_held || !own_piece(s)) return;
    m_held = 1'b1;
    m_sel  = s;
    m_kind = K_SELECT;
  endfunction

  function automatic void model_place(input logic [5:0] d, input int cyc_e);
    logic [3:0] cap;
    m_kind = K_NONE;
    if (m_over || !m_held) return;
    if (d == m_sel) begin
      m_held = 1'b0;
      m_kind = K_CANCEL;
      return;
    end
    if (own_piece(d)) return;
    cap = sq_val(d);
    m_board[d[5:3]][d[2:0]]         = sq_val(m_sel);
    m_board[m_sel[5:3]][m_sel[2:0]] = 4'h0;
    m_held = 1'b0;
    m_turn = ~m_turn;
    if (cap[2:0] == 3'd6) m_over = 1'b1;
    exp_q.push_back('{b: m_board, t: m_turn, cap: cap, over: m_over, cyc: cyc_e + 2});
    m_kind = K_COMMIT;
  endfunction

  task automatic compare_state(input string tag);
    check({tag, ".board"},     board,     m_board);
    check({tag, ".held"},      held,      m_held);
    check({tag, ".turn"},      turn,      m_turn);
    check({tag, ".game_over"}, game_over, m_over);
    check({tag, ".move_done"}, move_done, 1'b0);
    if (m_held) check({tag, ".sel_square"}, sel_square, m_sel);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check({tag, ".rst_board"}, board, m_board);
    check({tag, ".rst_held"},  held,  1'b0);
    check({tag, ".rst_turn"},  turn,  1'b0);
    check({tag, ".rst_cap"},   captured, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic req(input string tag, input bit p_pick, input bit p_place, input logic [5:0] sq);
    int cyc_e;
    @(posedge clk);
    #1;
    mouse_position = sq;
    pick_piece     = p_pick;
    place_piece    = p_place;
    cyc_e          = cyc;
    @(posedge clk);
    #1;
    pick_piece  = 1'b0;
    place_piece = 1'b0;
    m_kind      = K_NONE;
    if (p_pick && !p_place) model_pick(sq);
    else if (p_place && !p_pick) model_place(sq, cyc_e);
    @(negedge clk);
    if (m_kind == K_SELECT || m_kind == K_CANCEL) check({tag, ".held_latency"}, held, m_held);
    repeat (4) @(posedge clk);
    @(negedge clk);
    compare_state(tag);
  endtask

  // Commit monitor: every move_done pulse must match the oldest predicted commit.
  initial begin
    exp_t e;
    md_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && move_done) begin
        check("move_done_width", md_prev, 1'b0);
        if (exp_q.size() == 0) begin
          check("unexpected_move_done", move_done, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("commit.cycle",     cyc,       e.cyc);
          check("commit.board",     board,     e.b);
          check("commit.turn",      turn,      e.t);
          check("commit.captured",  captured,  e.cap);
          check("commit.game_over", game_over, e.over);
          check("commit.held",      held,      1'b0);
        end
      end
      md_prev = move_done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [5:0] s;
    int         r;
    n_pass = 0;
    n_total = 0;
    rst = 1'b0;
    mouse_position = '0;
    pick_piece = 1'b0;
    place_piece = 1'b0;

    // 1: simple pawn push
    do_reset("t1");
    req("t1_pick", 1, 0, 6'h30);
    check("t1.sel_square", sel_square, 6'h30);
    req("t1_place", 0, 1, 6'h20);
    check("t1.captured", captured, 4'h0);
    check("t1.dest", board[4][0], 4'h1);

    // 2: wrong colour and empty square picks
    do_reset("t2");
    req("t2_black", 1, 0, 6'h08);
    req("t2_empty", 1, 0, 6'h1A);

    // 3: cancel
    do_reset("t3");
    req("t3_pick", 1, 0, 6'h30);
    req("t3_cancel", 0, 1, 6'h30);

    // 4: place onto own piece is ignored, then a real move
    do_reset("t4");
    req("t4_pick", 1, 0, 6'h38);
    req("t4_own", 0, 1, 6'h39);
    req("t4_move", 0, 1, 6'h28);

    // 5: king capture ends the game
    do_reset("t5");
    req("t5_pick", 1, 0, 6'h3B);
    req("t5_take", 0, 1, 6'h04);
    check("t5.captured", captured, 4'hE);
    req("t5_over_pick", 1, 0, 6'h08);
    req("t5_over_place", 0, 1, 6'h18);
    do_reset("t5_after");

    // 6: simultaneous edges, then reset during COMMIT
    do_reset("t6");
    req("t6_both", 1, 1, 6'h30);
    req("t6_pick", 1, 0, 6'h30);
    @(posedge clk);
    #1;
    mouse_position = 6'h20;
    place_piece    = 1'b1;
    @(posedge clk);
    #1;
    place_piece = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check("t6.rst_commit_board", board, m_board);
    check("t6.rst_commit_turn",  turn,  1'b0);
    check("t6.rst_commit_held",  held,  1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_state("t6_after");

    // Randomized play against the model
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      s = 6'($urandom_range(0, 63));
      if (m_over && r == 9) begin
        do_reset("rnd_reset");
      end else if (r < 4) begin
        if ($urandom_range(0, 3) != 0) begin
          for (int k = 0; k < 64; k++) begin
            s = 6'($urandom_range(0, 63));
            if (own_piece(s)) break;
          end
        end
        req("rnd_pick", 1, 0, s);
      end else if (r < 8) begin
        if (m_held && $urandom_range(0, 7) == 0) s = m_sel;
        req("rnd_place", 0, 1, s);
      end else begin
        req("rnd_both", 1, 1, s);
      end
    end

    repeat (5) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
